instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Assembles decoded MIPS instruction fields into 32-bit instruction words. This is the reverse of the instruction-register field split.
- Used by the test-program loader to build instruction memory images. Accepts one field bundle per valid/ready handshake.
- Tags each word with a byte address from an internal program counter and buffers words in a 2-entry output queue. The downstream memory writer drains the queue.
- A start/done sequence bounds each program to PROG_LEN words.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first word after start.
- PROG_LEN, 16, number of words per program; legal range 1..65535.
- ADDR_W, 32, width of out_addr and of the address counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a program. Ignored while in RUN.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- fmt  in  2  instruction format: 0=R, 1=I, 2=J, 3=reserved.
- opcode  in  6  bits [31:26].
- rs  in  5  bits [25:21] (R/I formats).
- rt  in  5  bits [20:16] (R/I formats).
- rd  in  5  bits [15:11] (R format).
- shamt  in  5  bits [10:6] (R format).
- funct  in  6  bits [5:0] (R format).
- imm  in  16  bits [15:0] (I format).
- target  in  26  bits [25:0] (J format).
- out_valid  out  1  queue head is valid.
- out_ready  in  1  consumer takes head this cycle.
- out_instr  out  32  encoded word at queue head.
- out_addr  out  ADDR_W  byte address of the head word.
- busy  out  1  state is RUN.
- done  out  1  program complete; held until the next start.
- err  out  1  one-cycle pulse on a rejected bundle (only with ENC_CHECK_EN).

Behaviour:
- Reset (async, rst=1):
  - State IDLE, queue empty, address counter = BASE_ADDR, word count = 0.
  - in_ready=0, out_valid=0, out_instr=0, out_addr=0, busy=0, done=0, err=0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Loads addr=BASE_ADDR, count=0, clears done.
  - RUN -> DONE when count==PROG_LEN and the queue is empty.
  - DONE -> RUN on start, with the same reload as IDLE -> RUN.
  - start in RUN is ignored.
- in_ready = (state==RUN) && (queue occupancy<2) && (count<PROG_LEN). Combinational.
- A transfer occurs when in_valid && in_ready. On transfer:
  - The encoded word and the current addr are pushed.
  - addr += 4, wrapping modulo 2^ADDR_W.
  - count += 1.
- Encoding:
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
  - Fields unused by the selected format are ignored.
- Latency: a bundle accepted at edge N appears at the queue head (out_valid=1) after edge N when the queue was empty. Zero combinational path from inputs to out_instr.
- Queue:
  - 2 entries, FIFO order.
  - Head stays stable while out_valid && !out_ready.
  - Simultaneous push and pop at occupancy 1 leaves occupancy 1 and the new word becomes head.
  - At occupancy 2, in_ready=0 even if a pop occurs in the same cycle.
- out_instr and out_addr hold their last value when the queue is empty. Consumers must qualify them with out_valid.
- done rises on the cycle the state enters DONE. busy=0 in IDLE and DONE.
- Reset mid-program: the queue is flushed with no further out_valid, and all state returns to reset values.

Optional Feature:
- Macro: ENC_CHECK_EN.
- Defined: a bundle with fmt==3, or fmt==0 with opcode!=0, is still handshaken (in_ready as normal) but:
  - it is not pushed;
  - addr and count do not advance;
  - err pulses high for exactly the cycle after acceptance.
- Undefined:
  - fmt==3 is encoded as R format.
  - R format with nonzero opcode is encoded verbatim.
  - err is tied to 0.

Test Plan:
- Reset, start, R bundle (opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20) -> out_instr=0x012A4020, out_addr=BASE_ADDR, out_valid one cycle after acceptance.
- I bundle (opcode=0x23, rs=29, rt=8, imm=0xFFFC) then J bundle (opcode=2, target=0x0100004) -> 0x8FA8FFFC at BASE+0, then 0x08100004 at BASE+4.
- Hold out_ready=0 and offer 3 bundles -> exactly 2 accepted, in_ready=0, head stable. Release out_ready -> FIFO order preserved, third bundle then accepted.
- PROG_LEN=3, feed 5 bundles with out_ready=1 -> only 3 emitted, in_ready=0 after the third, done=1 and busy=0 once drained. A second start restarts from BASE_ADDR.
- BASE_ADDR=32'hFFFF_FFFC, two words -> addresses 0xFFFFFFFC then 0x00000000.
- With ENC_CHECK_EN: fmt=3 bundle -> err pulse, no out_valid, next valid word takes the unadvanced address. Without the macro: encoded as R.
- Assert rst with 2 words queued -> out_valid=0, in_ready=0, done=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS fields (R/I/J) into 32-bit words, tags each
// word with a byte address and buffers it in a 2-entry FIFO for a memory writer.
// A start/done sequence bounds each program to PROG_LEN words.
// Optional macro ENC_CHECK_EN: reject fmt==3 and R-format bundles with a nonzero
// opcode (handshaken, not pushed, err pulses the cycle after acceptance).
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          PROG_LEN  = 16,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // 17 bits holds count up to and including 65535
  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(PROG_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic [1:0]        occ;
  logic [31:0]       q_instr [2];
  logic [ADDR_W-1:0] q_addr  [2];
  logic [31:0]       enc_word;
  logic              bad, xfer, push, pop;

  // Format-directed packing; reserved fmt falls back to R layout
  always_comb begin
    enc_word = {opcode, rs, rt, rd, shamt, funct};
    case (fmt)
      2'd1:    enc_word = {opcode, rs, rt, imm};
      2'd2:    enc_word = {opcode, target};
      default: enc_word = {opcode, rs, rt, rd, shamt, funct};
    endcase
  end

`ifdef ENC_CHECK_EN
  assign bad = (fmt == 2'd3) || ((fmt == 2'd0) && (opcode != 6'd0));
`else
  assign bad = 1'b0;
`endif

  // Full queue blocks input even if the head drains this cycle
  assign in_ready  = (state == S_RUN) && (occ != 2'd2) && (count < LEN);
  assign xfer      = in_valid && in_ready;
  assign push      = xfer && !bad;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = q_instr[0];
  assign out_addr  = q_addr[0];
  assign busy      = (state == S_RUN);

  // Two-entry shift FIFO; slot 0 is the head and keeps its value when emptied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 2'd0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_addr[0]  <= '0;
      q_addr[1]  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            q_instr[0] <= enc_word;
            q_addr[0]  <= addr;
          end else begin
            q_instr[1] <= enc_word;
            q_addr[1]  <= addr;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) begin
            q_instr[0] <= q_instr[1];
            q_addr[0]  <= q_addr[1];
          end
          occ <= occ - 2'd1;
        end
        // push implies occ<2 and pop implies occ>0, so occ==1: replace head
        2'b11: begin
          q_instr[0] <= enc_word;
          q_addr[0]  <= addr;
        end
        default: ;
      endcase
    end
  end

  // Program sequencing, address/count tracking and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      addr  <= ADDR_W'(BASE_ADDR);
      count <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (push) begin
            addr  <= addr + ADDR_W'(4);
            count <= count + CNT_W'(1);
          end
          if ((count == LEN) && (occ == 2'd0)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state <= S_RUN;
            addr  <= ADDR_W'(BASE_ADDR);
            count <= '0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ENC_CHECK_EN
  // Rejection flag, one cycle after the rejected bundle's handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= xfer && bad;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed stimulus against a queue-based
// reference model of the encoder; every cycle compares handshake, head and flags.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam int          PLEN = 3;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy, done, err;
  logic [1:0]  fmt = '0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic [31:0] out_instr, out_addr;

  instr_encoder #(.BASE_ADDR(BASE), .PROG_LEN(PLEN), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  string cur = "";

  // reference model state
  typedef struct packed { logic [31:0] instr; logic [31:0] addr; } word_t;
  word_t       mq[$];
  bit          m_running, m_done, m_err;
  int          m_count;
  logic [31:0] m_addr, last_instr, last_addr;

  function automatic logic [31:0] model_enc();
    logic [31:0] op = 32'(opcode) * 32'd67108864;
    case (fmt)
      2'd1:    return op + 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(imm);
      2'd2:    return op + 32'(target);
      default: return op + 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 +
                      32'(rd) * 32'd2048 + 32'(shamt) * 32'd64 + 32'(funct);
    endcase
  endfunction

  function automatic bit model_bad();
`ifdef ENC_CHECK_EN
    return (fmt == 2'd3) || (fmt == 2'd0 && opcode != 6'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_running = 0; m_done = 0; m_err = 0; m_count = 0;
    m_addr = BASE; last_instr = 0; last_addr = 0;
  endfunction

  // One clock: entered at negedge with inputs driven, returns at next negedge
  task automatic step(output bit xfer);
    bit          exp_rdy, pop, pre_run;
    int          pre_cnt, pre_qs;
    logic [31:0] hi, ha;
    word_t       w;
    #1;
    exp_rdy = m_running && mq.size() < 2 && m_count < PLEN;
    hi = mq.size() > 0 ? mq[0].instr : last_instr;
    ha = mq.size() > 0 ? mq[0].addr  : last_addr;
    checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL %s in_ready got %b exp %b", cur, in_ready, exp_rdy); end
    checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL %s out_valid got %b exp %b", cur, out_valid, mq.size() > 0); end
    checks++; if (out_instr !== hi) begin errors++; $display("FAIL %s out_instr got %h exp %h", cur, out_instr, hi); end
    checks++; if (out_addr !== ha) begin errors++; $display("FAIL %s out_addr got %h exp %h", cur, out_addr, ha); end
    checks++; if (busy !== m_running) begin errors++; $display("FAIL %s busy got %b exp %b", cur, busy, m_running); end
    checks++; if (done !== m_done) begin errors++; $display("FAIL %s done got %b exp %b", cur, done, m_done); end
    checks++; if (err !== m_err) begin errors++; $display("FAIL %s err got %b exp %b", cur, err, m_err); end
    xfer = in_valid && exp_rdy;
    pop = out_ready && mq.size() > 0;
    w.instr = model_enc(); w.addr = m_addr;
    pre_run = m_running; pre_cnt = m_count; pre_qs = mq.size();
    @(posedge clk);
    if (!pre_run && start) begin
      m_running = 1; m_count = 0; m_addr = BASE; m_done = 0;
    end else if (pre_run && pre_cnt == PLEN && pre_qs == 0) begin
      m_running = 0; m_done = 1;
    end
    if (pop) begin last_instr = mq[0].instr; last_addr = mq[0].addr; void'(mq.pop_front()); end
    m_err = xfer && model_bad();
    if (xfer && !model_bad()) begin
      mq.push_back(w); m_addr = m_addr + 32'd4; m_count++;
    end
    @(negedge clk);
  endtask

  task automatic rand_bundle(input bit legal);
    fmt    = legal ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
    opcode = (legal && fmt == 2'd0) ? 6'd0 : 6'($urandom);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
    funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
  endtask

  task automatic do_start();
    bit x;
    start = 1; step(x); start = 0;
  endtask

  // Offer up to n_offer new bundles until the program completes; bounded
  task automatic run_stream(input int n_offer, input int rdy_pct, input bit legal,
                            input int budget, output int accepted);
    bit x; int offered = 0; int c = 0;
    accepted = 0;
    while (c < budget && !m_done) begin
      if (!in_valid && offered < n_offer && $urandom_range(0, 3) != 0) begin
        rand_bundle(legal); in_valid = 1; offered++;
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      step(x);
      if (x) begin accepted++; in_valid = 0; end
      c++;
    end
    in_valid = 0;
    checks++; if (!m_done) begin errors++; $display("FAIL %s timeout got done=%b exp 1", cur, done); end
  endtask

  task automatic test_reset();
    cur = "reset";
    model_reset();
    #1;
    checks++; if ({in_ready, out_valid, busy, done, err} !== 5'b0) begin errors++; $display("FAIL reset flags got %b exp 00000", {in_ready, out_valid, busy, done, err}); end
    checks++; if (out_instr !== 32'h0 || out_addr !== 32'h0) begin errors++; $display("FAIL reset head got %h/%h exp 0/0", out_instr, out_addr); end
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_encode();
    bit x; int a;
    cur = "encode";
    do_start();
    fmt = 0; opcode = 0; rs = 9; rt = 10; rd = 8; shamt = 0; funct = 6'h20;
    in_valid = 1; out_ready = 1; step(x); in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h012A4020 || out_addr !== BASE) begin errors++; $display("FAIL encode_r got %b %h@%h exp 1 012a4020@%h", out_valid, out_instr, out_addr, BASE); end
    fmt = 1; opcode = 6'h23; rs = 29; rt = 8; imm = 16'hFFFC;
    in_valid = 1; step(x);
    fmt = 2; opcode = 6'h02; target = 26'h0100004; out_ready = 0; step(x); in_valid = 0;
    checks++; if (out_instr !== 32'h8FA8FFFC || out_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL encode_i got %h@%h exp 8fa8fffc@fffffffc", out_instr, out_addr); end
    out_ready = 1; step(x);
    checks++; if (out_instr !== 32'h08100004 || out_addr !== 32'h0000_0000) begin errors++; $display("FAIL encode_j_wrap got %h@%h exp 08100004@00000000", out_instr, out_addr); end
    run_stream(0, 100, 1, 20, a);
  endtask

  task automatic test_backpressure();
    bit x; int acc = 0;
    cur = "backpressure";
    do_start();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (!in_valid) begin rand_bundle(1); in_valid = 1; end
      step(x);
      if (x) begin acc++; in_valid = 0; end
    end
    checks++; if (acc != 2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got %0d rdy=%b exp 2 rdy=0", acc, in_ready); end
    run_stream(0, 100, 1, 30, acc);
    checks++; if (acc != 1) begin errors++; $display("FAIL bp_third got %0d exp 1", acc); end
  endtask

  task automatic test_overrun();
    int a;
    cur = "overrun";
    do_start();
    run_stream(5, 100, 1, 60, a);
    checks++; if (a != PLEN) begin errors++; $display("FAIL overrun_count got %0d exp %0d", a, PLEN); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL overrun_done got busy=%b done=%b exp 0 1", busy, done); end
  endtask

  task automatic test_reserved();
    bit x; int a;
    cur = "reserved";
    do_start();
    rand_bundle(0); fmt = 3; out_ready = 1; in_valid = 1; step(x); in_valid = 0;
    checks++; if (x !== 1'b1) begin errors++; $display("FAIL reserved_hs got %b exp 1", x); end
`ifdef ENC_CHECK_EN
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reserved_rej got err=%b ov=%b exp 1 0", err, out_valid); end
`else
    checks++; if (err !== 1'b0 || out_valid !== 1'b1 || out_addr !== BASE) begin errors++; $display("FAIL reserved_r got err=%b ov=%b @%h exp 0 1 @%h", err, out_valid, out_addr, BASE); end
`endif
    run_stream(6, 100, 1, 60, a);
  endtask

  task automatic test_random();
    int a;
    cur = "random";
    for (int p = 0; p < 8; p++) begin
      do_start();
      // a stray start mid-program must be ignored
      start = 1; step(a[0]); start = 0;
      run_stream(40, $urandom_range(30, 100), 0, 400, a);
    end
  endtask

  task automatic test_reset_mid();
    bit x; int a;
    cur = "reset_mid";
    do_start();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (!in_valid) begin rand_bundle(1); in_valid = 1; end
      step(x);
      if (x) in_valid = 0;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_fill got ov=%b exp 1", out_valid); end
    rst = 1; #1;
    checks++; if ({out_valid, in_ready, done, busy} !== 4'b0) begin errors++; $display("FAIL mid_async got %b exp 0000", {out_valid, in_ready, done, busy}); end
    model_reset();
    @(negedge clk); rst = 0; in_valid = 0; out_ready = 1;
    step(x); step(x);
    do_start();
    run_stream(6, 80, 1, 60, a);
  endtask

  initial begin
    test_reset();
    test_encode();
    test_backpressure();
    test_overrun();
    test_reserved();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
